dac_multi_setpoint_ctrl: RTL and testbench
==========================================

Name: dac_multi_setpoint_ctrl

Overview:
Multi-channel successor to the single-channel DAC setpoint counter. It holds one saturating setpoint register per DAC channel and steps the selected channel up or down on less/more requests. Changed channels are marked dirty and written out to the SPI DAC driver one at a time, round-robin, over the dactrig/dacdone handshake. It also captures the driver's 32-bit readback word for debug display, and sits between the user controls and the DAC SPI driver.

Parameters:
DATA_W, 12, setpoint/DAC code width
NCH, 4, channel count (1..16)
STEP, 32, increment/decrement per request (1..2^DATA_W-1)
CMD_WU, 4'b0011, DAC command nibble "write and update"
TIMEOUT, 4096, max cycles waiting for dacdone before abort

Ports:
CLK50MHZ  in  1  system clock
RST  in  1  asynchronous, active-low reset
less  in  1  step selected channel down; one step per cycle while high
more  in  1  step selected channel up; one step per cycle while high
ch_sel  in  $clog2(NCH) (min 1)  channel targeted by less/more
data  out  DATA_W  code sent to the driver
address  out  4  DAC channel address sent to the driver
command  out  4  DAC command, constant CMD_WU
dactrig  out  1  one-cycle start pulse to the driver
dacdone  in  1  one-cycle completion pulse from the driver
dac_datareceived  in  32  driver readback word, valid with dacdone
rx_byte_sel  in  2  byte of the captured readback to expose
rx_byte  out  8  selected byte of the captured readback (0 = bits 7:0)
busy  out  1  transfer in flight (TRIG or WAIT)
timeout_err  out  1  sticky; set on handshake timeout

Behaviour:
- Reset (RST=0, async): all setpoints 0; all dirty bits 0; data=0; address=0; dactrig=0; busy=0; timeout_err=0; captured readback=0; rr pointer=0; FSM=IDLE. command is always CMD_WU.
- Step arithmetic (DATA_W+1 bits, unsigned; MAXV=2^DATA_W-1):
  - down: sp<STEP -> 0, else sp-STEP.
  - up: sp>MAXV-STEP -> MAXV, else sp+STEP.
  - less and more both high: no change.
  - ch_sel>=NCH: request ignored.
- Dirty bits: a request that changes the value sets dirty[ch_sel]. A request at a bound (0 down, MAXV up) does not set it.
- FSM IDLE:
  - If any dirty bit is set, pick the first dirty channel at index >= rr (wrapping).
  - Latch data=sp[ch] and address=ch, clear dirty[ch], assert dactrig, go TRIG.
- FSM TRIG (1 cycle): deassert dactrig, go WAIT.
- FSM WAIT:
  - On dacdone: latch dac_datareceived, set rr=ch+1 mod NCH, go IDLE.
  - On TIMEOUT cycles without dacdone: set timeout_err, set dirty[ch] again, go IDLE.
- dacdone outside WAIT is ignored.
- Latency: a request sampled at edge N updates sp/dirty at N. At edge N+1 the FSM leaves IDLE, so dactrig is high in cycle N+1..N+2 (exactly one cycle).
- Back-to-back transfers: IDLE lasts one cycle between a transfer's dacdone and the next dactrig.
- Collisions:
  - If a step hits the channel whose dirty bit is being cleared in the same cycle, set wins. The channel is re-sent later with the new value.
  - data/address stay stable from dactrig until the next IDLE pick.
- Reset mid-transfer: FSM to IDLE, dactrig 0, pending updates discarded.
- timeout_err clears only on reset.

Decomposition:
- Package dac_pkg holds:
  - DAC_CMD_WRITE_UPDATE=4'b0011
  - DAC_ADDR_ALL=4'b1111
  - FSM state enum {IDLE, TRIG, WAIT}
  - saturating step function
- One sub-module, dac_rr_pick: combinational round-robin selector. Inputs: dirty[NCH], rr pointer. Outputs: grant index and any-valid.

Test Plan:
1. Reset, more high 3 cycles on ch 2, driver acks after 10 cycles -> sp[2]=96; first dactrig with address=2, data=32 or later. Final transfer carries data=96. busy low at end.
2. sp[0]=16, pulse less -> sp[0]=0, one transfer with data=0. Pulse less again -> no dactrig.
3. sp[1]=4064 (MAXV-31), pulse more -> 4095. Pulse more again -> no change, no dactrig.
4. Dirty ch 0, 1, 3 set in the same cycle, rr=1 -> transfer order 1, 3, 0, each dactrig exactly one cycle.
5. No dacdone for TIMEOUT cycles -> timeout_err=1. Same channel is retried; ack returns FSM to IDLE.
6. dacdone with dac_datareceived=32'hA1B2C3D4, rx_byte_sel 0..3 -> rx_byte D4, C3, B2, A1. Assert RST mid-WAIT -> all outputs reset values.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared definitions for the multi-channel DAC setpoint controller.
//   DAC_CMD_WRITE_UPDATE : DAC command nibble "write input register and update"
//   DAC_ADDR_ALL         : DAC broadcast address
//   dac_state_e          : transfer FSM states
//   sat_step()           : saturating up/down step on an unsigned code
package dac_pkg;

    localparam logic [3:0] DAC_CMD_WRITE_UPDATE = 4'b0011;
    localparam logic [3:0] DAC_ADDR_ALL         = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRIG = 2'd1,
        WAIT = 2'd2
    } dac_state_e;

    // Worked in 32 bits so one function serves every code width; the
    // comparisons are arranged so sp+step / sp-step never wrap.
    function automatic logic [31:0] sat_step(input logic [31:0] sp,
                                             input logic [31:0] step,
                                             input logic [31:0] maxv,
                                             input logic        up);
        logic [31:0] r;
        if (up) r = (sp > maxv - step) ? maxv : sp + step;
        else    r = (sp < step) ? 32'd0 : sp - step;
        return r;
    endfunction

endpackage

// File: rtl/dac_rr_pick.sv
// Combinational round-robin selector.
//   dirty : per-channel request bits
//   rr    : channel with highest priority this cycle
//   grant : first set dirty bit at index >= rr, wrapping past NCH-1
//   any   : at least one dirty bit is set (grant is meaningful)
module dac_rr_pick #(
    parameter  int NCH = 4,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] dirty,
    input  logic [CHW-1:0] rr,
    output logic [CHW-1:0] grant,
    output logic           any
);

    logic [CHW:0] idx;

    // Scan from the farthest offset down to offset 0 so the nearest
    // dirty channel (smallest distance from rr) is the last to assign.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = |dirty;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = {1'b0, rr} + (CHW+1)'(i);
            if (idx >= (CHW+1)'(NCH)) idx = idx - (CHW+1)'(NCH);
            if (dirty[idx[CHW-1:0]]) grant = idx[CHW-1:0];
        end
    end

endmodule

// File: rtl/dac_multi_setpoint_ctrl.sv
// Multi-channel DAC setpoint controller.
// Keeps a saturating setpoint per channel, stepped by less/more on the
// channel chosen by ch_sel. Changed channels are flagged dirty and pushed to
// the SPI DAC driver one at a time, round-robin, over dactrig/dacdone.
//   CLK50MHZ, RST        : clock, async active-low reset
//   less, more, ch_sel   : step request (one step per cycle while held)
//   data, address,
//   command, dactrig     : transfer to the driver (dactrig = 1-cycle start)
//   dacdone,
//   dac_datareceived     : driver completion pulse and readback word
//   rx_byte_sel, rx_byte : byte view of the last captured readback
//   busy, timeout_err    : transfer in flight / sticky handshake timeout
module dac_multi_setpoint_ctrl
    import dac_pkg::*;
#(
    parameter  int         DATA_W  = 12,
    parameter  int         NCH     = 4,
    parameter  int         STEP    = 32,
    parameter  logic [3:0] CMD_WU  = DAC_CMD_WRITE_UPDATE,
    parameter  int         TIMEOUT = 4096,
    localparam int         CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              CLK50MHZ,
    input  logic              RST,
    input  logic              less,
    input  logic              more,
    input  logic [CHW-1:0]    ch_sel,
    output logic [DATA_W-1:0] data,
    output logic [3:0]        address,
    output logic [3:0]        command,
    output logic              dactrig,
    input  logic              dacdone,
    input  logic [31:0]       dac_datareceived,
    input  logic [1:0]        rx_byte_sel,
    output logic [7:0]        rx_byte,
    output logic              busy,
    output logic              timeout_err
);

    localparam int          TW   = $clog2(TIMEOUT + 1);
    localparam logic [31:0] MAXV = 32'((64'd1 << DATA_W) - 64'd1);

    dac_state_e                  state;
    logic [NCH-1:0][DATA_W-1:0]  sp;
    logic [NCH-1:0]              dirty, dirty_nxt;
    logic [CHW-1:0]              rr, cur_ch, grant;
    logic                        any_dirty;
    logic [TW-1:0]               tmo_cnt;
    logic [31:0]                 rx_word;
    logic                        req_vld, req_chg, tmo_hit;
    logic [31:0]                 step_res;
    logic [DATA_W-1:0]           sp_new;
    logic                        unused_step_hi;

    assign command = CMD_WU;
    assign busy    = (state != IDLE);
    assign rx_byte = rx_word[rx_byte_sel*8 +: 8];

    // less+more together is a no-op; out-of-range channels are dropped.
    assign req_vld  = (less ^ more) && (32'(ch_sel) < 32'(NCH));
    assign step_res = sat_step(32'(sp[ch_sel]), 32'(STEP), MAXV, more);
    assign sp_new   = step_res[DATA_W-1:0];
    assign unused_step_hi = ^step_res[31:DATA_W];
    // A step pinned at a bound leaves the value alone and must not retrigger.
    assign req_chg  = req_vld && (sp_new != sp[ch_sel]);
    assign tmo_hit  = (state == WAIT) && !dacdone &&
                      (tmo_cnt == TW'(TIMEOUT - 1));

    dac_rr_pick #(.NCH(NCH)) u_pick (
        .dirty (dirty),
        .rr    (rr),
        .grant (grant),
        .any   (any_dirty)
    );

    // Set after clear: a step landing on the channel being picked keeps it
    // dirty so the newer value goes out on a later transfer.
    always_comb begin
        dirty_nxt = dirty;
        if (state == IDLE && any_dirty) dirty_nxt[grant]  = 1'b0;
        if (tmo_hit)                    dirty_nxt[cur_ch] = 1'b1;
        if (req_chg)                    dirty_nxt[ch_sel] = 1'b1;
    end

    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            sp          <= '0;
            dirty       <= '0;
            rr          <= '0;
            cur_ch      <= '0;
            data        <= '0;
            address     <= '0;
            dactrig     <= 1'b0;
            tmo_cnt     <= '0;
            rx_word     <= '0;
            timeout_err <= 1'b0;
        end else begin
            dirty   <= dirty_nxt;
            dactrig <= 1'b0;
            if (req_chg) sp[ch_sel] <= sp_new;
            case (state)
                IDLE: if (any_dirty) begin
                    cur_ch  <= grant;
                    data    <= sp[grant];
                    address <= 4'(grant);
                    dactrig <= 1'b1;
                    state   <= TRIG;
                end
                TRIG: begin
                    tmo_cnt <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (dacdone) begin
                        rx_word <= dac_datareceived;
                        rr      <= (cur_ch == CHW'(NCH - 1)) ? '0 : cur_ch + CHW'(1);
                        state   <= IDLE;
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_multi_setpoint_ctrl.sv
module tb_dac_multi_setpoint_ctrl;
    localparam int DATA_W  = 12;
    localparam int NCH     = 4;
    localparam int STEP    = 32;
    localparam int TIMEOUT = 4096;
    localparam int MAXV    = (1 << DATA_W) - 1;

    logic              CLK50MHZ = 1'b0;
    logic              RST = 1'b0;
    logic              less = 1'b0, more = 1'b0, dacdone = 1'b0;
    logic [1:0]        ch_sel = '0, rx_byte_sel = '0;
    logic [31:0]       dac_datareceived = '0;
    logic [DATA_W-1:0] data;
    logic [3:0]        address, command;
    logic              dactrig, busy, timeout_err;
    logic [7:0]        rx_byte;

    dac_multi_setpoint_ctrl #(.DATA_W(DATA_W), .NCH(NCH), .STEP(STEP),
                              .CMD_WU(4'b0011), .TIMEOUT(TIMEOUT)) dut (
        .CLK50MHZ(CLK50MHZ), .RST(RST), .less(less), .more(more),
        .ch_sel(ch_sel), .data(data), .address(address), .command(command),
        .dactrig(dactrig), .dacdone(dacdone),
        .dac_datareceived(dac_datareceived), .rx_byte_sel(rx_byte_sel),
        .rx_byte(rx_byte), .busy(busy), .timeout_err(timeout_err));

    always #10 CLK50MHZ = ~CLK50MHZ;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: setpoints, pending set, round-robin pointer and the
    // progress of the one transfer that may be outstanding.
    int          m_sp[NCH];
    bit          m_dirty[NCH];
    int          m_rr, m_ch, m_cnt, m_data, m_addr;
    int          m_xfer;      // 0 none, 1 just started, 2 awaiting done
    bit          m_trig, m_terr;
    logic [31:0] m_rx;

    // Bench-side driver state and stimulus knobs.
    int          ack_wait;
    bit          fix_word;
    int          bias_ch, bias_up, cyc_no;

    task automatic model_reset();
        foreach (m_sp[i]) begin m_sp[i] = 0; m_dirty[i] = 0; end
        m_rr = 0; m_ch = 0; m_cnt = 0; m_data = 0; m_addr = 0;
        m_xfer = 0; m_trig = 0; m_terr = 0; m_rx = '0; ack_wait = 0;
    endtask

    task automatic model_edge(input bit l, input bit m, input int ch,
                              input bit done, input logic [31:0] word);
        bit found;
        int nv;
        found = 0;
        if (m_xfer == 0) begin
            for (int k = 0; k < NCH; k++)
                if (!found && m_dirty[(m_rr + k) % NCH]) begin
                    found = 1;
                    m_ch  = (m_rr + k) % NCH;
                end
            if (found) begin
                m_dirty[m_ch] = 0;
                m_data = m_sp[m_ch];
                m_addr = m_ch;
                m_xfer = 1;
            end
        end else if (m_xfer == 1) begin
            m_xfer = 2;
            m_cnt  = 0;
        end else if (done) begin
            m_rx   = word;
            m_rr   = (m_ch + 1) % NCH;
            m_xfer = 0;
        end else begin
            m_cnt++;
            if (m_cnt == TIMEOUT) begin
                m_terr = 1;
                m_dirty[m_ch] = 1;
                m_xfer = 0;
            end
        end
        m_trig = found;
        if (ch < NCH && l != m) begin
            if (m) nv = (m_sp[ch] + STEP > MAXV) ? MAXV : m_sp[ch] + STEP;
            else   nv = (m_sp[ch] < STEP) ? 0 : m_sp[ch] - STEP;
            if (nv != m_sp[ch]) begin
                m_sp[ch] = nv;
                m_dirty[ch] = 1;
            end
        end
    endtask

    task automatic cyc(input bit req_en, input bit ack_en);
        bit l, m, d;
        int r;
        logic [1:0] c;
        logic [31:0] w;
        l = 0; m = 0; d = 0;
        c = 2'($urandom_range(0, 3));
        w = fix_word ? 32'hA1B2C3D4 : $urandom;
        if (cyc_no % 50 == 0) begin
            bias_ch = $urandom_range(0, NCH - 1);
            bias_up = $urandom_range(0, 1);
        end
        cyc_no++;
        if (req_en) begin
            r = $urandom_range(0, 9);
            if (r <= 5) begin c = 2'(bias_ch); l = !bias_up; m = bias_up; end
            else if (r == 6) begin l = 1; m = 1; end
            else if (r == 7) begin l = $urandom_range(0, 1); m = !l; end
        end
        if (m_xfer == 2 && ack_en) begin
            if (ack_wait <= 1) d = 1;
            else ack_wait--;
        end else if (m_xfer == 0) begin
            d = ($urandom_range(0, 31) == 0);   // stray pulse, must be ignored
        end
        less = l; more = m; ch_sel = c; dacdone = d; dac_datareceived = w;
        rx_byte_sel = 2'($urandom_range(0, 3));
        @(posedge CLK50MHZ); #1;
        model_edge(l, m, int'(c), d, w);
        chk("dactrig", dactrig, m_trig);
        chk("busy", busy, m_xfer != 0);
        chk("timeout_err", timeout_err, m_terr);
        chk("rx_byte", rx_byte, m_rx[rx_byte_sel*8 +: 8]);
        if (m_xfer != 0) begin
            chk("address", address, m_addr);
            chk("data", data, m_data);
        end
        if (m_trig) ack_wait = $urandom_range(1, 12);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_data"}, data, 0);
        chk({tag, "_address"}, address, 0);
        chk({tag, "_dactrig"}, dactrig, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
        chk({tag, "_rx_byte"}, rx_byte, 0);
        chk({tag, "_command"}, command, 4'b0011);
    endtask

    task automatic do_reset(input string tag);
        #3 RST = 1'b0;
        less = 0; more = 0; dacdone = 0;
        #3;
        model_reset();
        check_reset_outputs(tag);
        @(negedge CLK50MHZ);
        RST = 1'b1;
    endtask

    int guard;
    bit [7:0] exp_b[4];

    initial begin
        fix_word = 0; cyc_no = 0; bias_ch = 0; bias_up = 1;
        model_reset();
        do_reset("rst");

        repeat (3000) cyc(1, 1);

        // Starve the handshake until a timeout, then let the retry complete.
        guard = 0;
        while (m_xfer == 0 && guard < 300) begin cyc(1, 0); guard++; end
        chk("xfer_started", m_xfer != 0, 1);
        repeat (TIMEOUT + 20) cyc(0, 0);
        chk("timeout_set", timeout_err, 1);
        repeat (300) cyc(1, 1);
        chk("timeout_sticky", timeout_err, 1);

        // Known readback word, exposed byte by byte.
        fix_word = 1;
        guard = 0;
        while (m_rx != 32'hA1B2C3D4 && guard < 500) begin cyc(1, 1); guard++; end
        fix_word = 0;
        exp_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        for (int b = 0; b < 4; b++) begin
            rx_byte_sel = 2'(b);
            #1 chk("rx_byte_sel", rx_byte, exp_b[b]);
        end

        // Reset in the middle of a transfer.
        guard = 0;
        while (m_xfer != 2 && guard < 500) begin cyc(1, 0); guard++; end
        chk("reached_wait", busy, 1);
        do_reset("midrst");
        repeat (800) cyc(1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
